// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encodings, register
// offsets and the device base address used by the bridge decoder.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SERV = 2'd2
    } irq_state_e;

    localparam logic [1:0] REG_MASK   = 2'd0;
    localparam logic [1:0] REG_EDGE   = 2'd1;
    localparam logic [1:0] REG_PEND   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Byte base in the bridge decode table, directly after the two timer windows.
    localparam logic [31:0] IRQ_CTRL_BASE = 32'h8000_0300;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of req and whether any bit is set.
module irq_prio_enc #(
    parameter int NSRC = 6,
    parameter int IDW  = 3
) (
    input  logic [NSRC-1:0] req,
    output logic [IDW-1:0]  idx,
    output logic            vld
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDW'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches sources with per-source mask and
// edge/level mode, and walks one request at a time through request/ack/eoi.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 6,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] hw_int,
    input  logic            we,
    input  logic [29:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq,
    output logic [IDW-1:0]  irq_id,
    input  logic            ack,
    input  logic            eoi
);

    logic [NSRC-1:0] mask_q, edge_q, pend_q, prev_q;
    logic [NSRC-1:0] pend_d, rise, w1c, ack_clr, eligible, id_onehot;
    logic [IDW-1:0]  irq_id_q, irq_id_d, sel_idx;
    logic            sel_vld, held_elig;
    logic            wr_mask, wr_edge, wr_pend, take;
    logic [1:0]      reg_sel;
    irq_state_e      state_q, state_d;

    // Only the register select and the low NSRC data bits carry meaning.
    logic unused_bits;
    assign unused_bits = ^{addr[29:2], wdata[31:NSRC]};

    assign reg_sel = addr[1:0];
    assign wr_mask = we && (reg_sel == REG_MASK);
    assign wr_edge = we && (reg_sel == REG_EDGE);
    assign wr_pend = we && (reg_sel == REG_PEND);

    assign eligible  = pend_q & mask_q;
    assign id_onehot = NSRC'(1) << irq_id_q;
    assign held_elig = |(eligible & id_onehot);
    assign take      = (state_q == IRQ_REQ) && ack;

    irq_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio_enc (
        .req (eligible),
        .idx (sel_idx),
        .vld (sel_vld)
    );

    // Edge bits: a new rising edge beats any clear in the same cycle.
    assign rise    = hw_int & ~prev_q;
    assign w1c     = wr_pend ? wdata[NSRC-1:0] : '0;
    assign ack_clr = take ? id_onehot : '0;
    assign pend_d  = (edge_q & (rise | (pend_q & ~(w1c | ack_clr))))
                   | (~edge_q & hw_int);

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IRQ_IDLE: begin
                if (sel_vld) begin
                    state_d  = IRQ_REQ;
                    irq_id_d = sel_idx;
                end
            end
            IRQ_REQ: begin
                if (ack) begin
                    state_d = IRQ_SERV;
                end else if (!held_elig) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_SERV: begin
                if (eoi) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q   <= '0;
            edge_q   <= '0;
            pend_q   <= '0;
            prev_q   <= '0;
            state_q  <= IRQ_IDLE;
            irq_id_q <= '0;
        end else begin
            if (wr_mask) mask_q <= wdata[NSRC-1:0];
            if (wr_edge) edge_q <= wdata[NSRC-1:0];
            pend_q   <= pend_d;
            prev_q   <= hw_int;
            state_q  <= state_d;
            irq_id_q <= irq_id_d;
        end
    end

    assign irq    = (state_q == IRQ_REQ);
    assign irq_id = irq_id_q;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_MASK:   rdata[NSRC-1:0] = mask_q;
            REG_EDGE:   rdata[NSRC-1:0] = edge_q;
            REG_PEND:   rdata[NSRC-1:0] = pend_q;
            REG_STATUS: rdata[IDW+1:0]  = {state_q, irq_id_q};
            default:    rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the controller.
module tb_irq_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_REQ  = 1;
    localparam int S_SERV = 2;

    logic        clk;
    logic        reset;
    logic [5:0]  hw_int;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [2:0]  irq_id;
    logic        ack;
    logic        eoi;

    int total = 0;
    int bad   = 0;

    logic [5:0] m_mask, m_edge, m_pend, m_prev;
    int         m_state, m_id;

    irq_ctrl #(
        .NSRC (6),
        .IDW  (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .hw_int (hw_int),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq),
        .irq_id (irq_id),
        .ack    (ack),
        .eoi    (eoi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask = '0; m_edge = '0; m_pend = '0; m_prev = '0;
        m_state = S_IDLE; m_id = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {26'b0, m_mask};
            2'd1:    return {26'b0, m_edge};
            2'd2:    return {26'b0, m_pend};
            default: return 32'(m_state * 8 + m_id);
        endcase
    endfunction

    // One clock edge of the controller as described in plain terms.
    task automatic model_step();
        logic [5:0] elig, npend;
        int first;
        bit clr;
        elig  = m_pend & m_mask;
        first = -1;
        for (int i = 5; i >= 0; i--) if (elig[i]) first = i;
        for (int i = 0; i < 6; i++) begin
            if (m_edge[i]) begin
                clr = (we && addr[1:0] == 2'd2 && wdata[i]) ||
                      (m_state == S_REQ && ack && m_id == i);
                if (hw_int[i] && !m_prev[i]) npend[i] = 1'b1;
                else if (clr)                npend[i] = 1'b0;
                else                         npend[i] = m_pend[i];
            end else begin
                npend[i] = hw_int[i];
            end
        end
        case (m_state)
            S_IDLE: if (first >= 0) begin m_state = S_REQ; m_id = first; end
            S_REQ: begin
                if (ack)                m_state = S_SERV;
                else if (!elig[m_id])   m_state = S_IDLE;
            end
            default: if (eoi) m_state = S_IDLE;
        endcase
        if (we && addr[1:0] == 2'd0) m_mask = wdata[5:0];
        if (we && addr[1:0] == 2'd1) m_edge = wdata[5:0];
        m_pend = npend;
        m_prev = hw_int;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("irq", {31'b0, irq}, {31'b0, m_state == S_REQ});
        chk("irq_id", {29'b0, irq_id}, 32'(m_id));
        chk("rdata", rdata, model_read(addr[1:0]));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = {28'b0, a}; wdata = d;
        cycle();
        we = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = {28'b0, a};
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic to_idle();
        hw_int = '0;
        wr(2'd0, 32'h0);
        eoi = 1'b1;
        cycle();
        eoi = 1'b0;
        cycle();
        wr(2'd2, 32'h3f);
        peek("idle_status_state", 2'd3, model_read(2'd3));
    endtask

    initial begin
        reset = 1'b0; hw_int = '0; we = 1'b0; addr = '0; wdata = '0;
        ack = 1'b0; eoi = 1'b0;
        model_reset();
        #12;
        chk("rst_irq", {31'b0, irq}, 32'h0);
        peek("rst_mask", 2'd0, 32'h0);
        peek("rst_status", 2'd3, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Edge source 0: pend at k, request after k+1, ack clears, eoi idles.
        wr(2'd0, 32'h01);
        wr(2'd1, 32'h01);
        hw_int = 6'h01; addr = 30'd2;
        cycle();
        chk("t2_pend", rdata, 32'h01);
        chk("t2_irq_early", {31'b0, irq}, 32'h0);
        cycle();
        chk("t2_irq", {31'b0, irq}, 32'h1);
        chk("t2_id", {29'b0, irq_id}, 32'h0);
        ack = 1'b1; cycle(); ack = 1'b0;
        chk("t2_irq_drop", {31'b0, irq}, 32'h0);
        peek("t2_pend_clr", 2'd2, 32'h00);
        peek("t2_serv", 2'd3, 32'h10);
        eoi = 1'b1; cycle(); eoi = 1'b0;
        peek("t2_idle", 2'd3, 32'h00);
        to_idle();

        // Level sources, no preemption, back-to-back after eoi.
        wr(2'd1, 32'h00);
        wr(2'd0, 32'h07);
        hw_int = 6'h06;
        cycle(); cycle();
        chk("t3_id1", {29'b0, irq_id}, 32'h1);
        hw_int = 6'h07;
        cycle();
        chk("t3_hold", {29'b0, irq_id}, 32'h1);
        chk("t3_hold_irq", {31'b0, irq}, 32'h1);
        ack = 1'b1; cycle(); ack = 1'b0;
        eoi = 1'b1; cycle(); eoi = 1'b0;
        cycle();
        chk("t3_b2b_irq", {31'b0, irq}, 32'h1);
        chk("t3_b2b_id", {29'b0, irq_id}, 32'h0);
        to_idle();

        // Level source withdrawn before ack.
        wr(2'd0, 32'h04);
        hw_int = 6'h04;
        cycle(); cycle();
        chk("t4_req", {31'b0, irq}, 32'h1);
        hw_int = 6'h00;
        cycle(); cycle();
        chk("t4_withdraw", {31'b0, irq}, 32'h0);
        peek("t4_status", 2'd3, 32'h02);
        to_idle();

        // W1C against a simultaneous rising edge, then ack beats a mask write.
        wr(2'd1, 32'h08);
        wr(2'd0, 32'h08);
        hw_int = 6'h08;
        we = 1'b1; addr = 30'd2; wdata = 32'h08;
        cycle();
        we = 1'b0;
        peek("t5_set_wins", 2'd2, 32'h08);
        cycle();
        chk("t6_req_id", {29'b0, irq_id}, 32'h3);
        ack = 1'b1;
        wr(2'd0, 32'h00);
        ack = 1'b0;
        peek("t6_ack_wins", 2'd3, 32'h13);
        eoi = 1'b1; cycle(); eoi = 1'b0;
        peek("t6_idle", 2'd3, 32'h03);
        eoi = 1'b1; cycle(); eoi = 1'b0;
        peek("t6_eoi_idle", 2'd3, 32'h03);
        to_idle();
        wr(2'd1, 32'h00);

        // Asynchronous reset in the middle of a request.
        wr(2'd0, 32'h01);
        hw_int = 6'h01;
        cycle(); cycle();
        chk("t1_pre_req", {31'b0, irq}, 32'h1);
        #3 reset = 1'b0;
        model_reset();
        #1;
        chk("t1_irq", {31'b0, irq}, 32'h0);
        for (int a = 0; a < 4; a++) peek("t1_reg", 2'(a), 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        hw_int = '0;
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(3) == 0) hw_int = hw_int ^ 6'(1 << $urandom_range(5));
            we    = ($urandom_range(7) == 0);
            addr  = 30'($urandom);
            wdata = $urandom;
            ack   = (m_state == S_REQ)  ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
            eoi   = (m_state == S_SERV) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
            cycle();
        end
        we = 1'b0; ack = 1'b0; eoi = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
